test_result_monitor: RTL and testbench

- Parametrised simulation/test monitor that watches committed PCs from one or more harts and reports a sticky pass/fail/timeout verdict.
- Sits in the top-level test harness beside the core(s), imem and dmem, and drives the harness `result` output.
- Generalises single-PC success/fail detection with:
  - multiple harts;
  - a global cycle timeout;
  - per-hart hang detection;
  - retire and cycle counters;
  - a defined verdict priority.

---
 rtl/test_result_monitor_if.sv | 37 +++
 rtl/test_result_monitor.sv | 170 +++++++++++++++++
 tb/tb_test_result_monitor.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_result_monitor_if.sv
// rtl/test_result_monitor_if.sv - commit/verdict bundle between a test harness and test_result_monitor
// Signals:
//   enable        harness -> monitor  start monitoring (sampled only while idle)
//   commit_valid  harness -> monitor  per-hart commit strobe
//   commit_pc     harness -> monitor  per-hart committed PC, hart h at [h*PC_WIDTH +: PC_WIDTH]
//   result        monitor -> harness  00 running/idle, 10 pass, 01 fail, 11 timeout
//   done          monitor -> harness  result != 00
//   hart_status   monitor -> harness  per hart 00 RUN, 10 PASS, 01 FAIL, 11 HANG
//   fail_hart     monitor -> harness  lowest failing hart, valid when result == 01
//   cycle_count   monitor -> harness  cycles spent running
//   retire_count  monitor -> harness  commits accepted while running
interface test_result_monitor_if #(
  parameter int NUM_HARTS = 2,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32,
  parameter int FH_WIDTH  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
);
  logic                          enable;
  logic [NUM_HARTS-1:0]          commit_valid;
  logic [NUM_HARTS*PC_WIDTH-1:0] commit_pc;
  logic [1:0]                    result;
  logic                          done;
  logic [2*NUM_HARTS-1:0]        hart_status;
  logic [FH_WIDTH-1:0]           fail_hart;
  logic [CNT_WIDTH-1:0]          cycle_count;
  logic [CNT_WIDTH-1:0]          retire_count;

  modport master (
    output enable, commit_valid, commit_pc,
    input  result, done, hart_status, fail_hart, cycle_count, retire_count
  );

  modport slave (
    input  enable, commit_valid, commit_pc,
    output result, done, hart_status, fail_hart, cycle_count, retire_count
  );
endinterface

// File: rtl/test_result_monitor.sv
// rtl/test_result_monitor.sv - multi-hart committed-PC monitor with sticky pass/fail/timeout verdict
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset; clears every output and all hart state
//   mon    slave side of test_result_monitor_if (commit inputs in, verdict and counters out)
module test_result_monitor #(
  parameter int                  NUM_HARTS      = 2,
  parameter int                  PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0] PC_SUCCESS     = 32'h0000_1000,
  parameter logic [PC_WIDTH-1:0] PC_FAILED      = 32'h0000_2000,
  parameter int                  TIMEOUT_CYCLES = 100000,
  parameter int                  HANG_LIMIT     = 1024,
  parameter int                  CNT_WIDTH      = 32,
  parameter int                  FH_WIDTH       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input logic                  clk,
  input logic                  reset,
  test_result_monitor_if.slave mon
);

  // Hang counter only needs to reach HANG_LIMIT; once it does the hart stops counting.
  localparam int                 HC_W       = (HANG_LIMIT > 0) ? $clog2(HANG_LIMIT + 1) : 1;
  localparam logic [HC_W-1:0]    HANG_LIM_C = HC_W'(HANG_LIMIT);
  localparam bit                 HANG_EN    = (HANG_LIMIT != 0);
  localparam bit                 TO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] HS_RUN  = 2'b00;
  localparam logic [1:0] HS_PASS = 2'b10;
  localparam logic [1:0] HS_FAIL = 2'b01;
  localparam logic [1:0] HS_HANG = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t                 state;
  logic [1:0]             result_q;
  logic                   done_q;
  logic [FH_WIDTH-1:0]    fail_hart_q;
  logic [CNT_WIDTH-1:0]   cycle_count_q;
  logic [CNT_WIDTH-1:0]   retire_count_q;
  logic [2*NUM_HARTS-1:0] hart_status_q;

  logic [HC_W-1:0]        hang_cnt [NUM_HARTS];
  logic [PC_WIDTH-1:0]    last_pc  [NUM_HARTS];

  logic [PC_WIDTH-1:0]    pc_h     [NUM_HARTS];
  logic [HC_W-1:0]        hang_nxt [NUM_HARTS];
  logic [NUM_HARTS-1:0]   accept;
  logic [CNT_WIDTH:0]     n_acc;
  logic [CNT_WIDTH:0]     retire_sum;
  logic [CNT_WIDTH-1:0]   retire_nxt;
  logic                   any_fail;
  logic                   all_pass;
  logic [FH_WIDTH-1:0]    first_fail;

  // A commit is accepted only while monitoring and while its hart has no verdict yet.
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      pc_h[h]   = mon.commit_pc[h*PC_WIDTH +: PC_WIDTH];
      accept[h] = (state == S_RUN) && mon.commit_valid[h] && (hart_status_q[2*h +: 2] == HS_RUN);
      if (pc_h[h] == last_pc[h]) begin
        hang_nxt[h] = (hang_cnt[h] == '1) ? hang_cnt[h] : hang_cnt[h] + HC_W'(1);
      end else begin
        hang_nxt[h] = HC_W'(1);
      end
    end
  end

  // Saturating retire accumulation: one spare bit catches the carry out.
  always_comb begin
    n_acc = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      n_acc = n_acc + (CNT_WIDTH+1)'(accept[h]);
    end
    retire_sum = {1'b0, retire_count_q} + n_acc;
    retire_nxt = retire_sum[CNT_WIDTH] ? '1 : retire_sum[CNT_WIDTH-1:0];
  end

  // Bit 0 of a hart status is set for both FAIL and HANG. Scanning downward
  // leaves the lowest failing index in first_fail.
  always_comb begin
    any_fail   = 1'b0;
    all_pass   = 1'b1;
    first_fail = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (hart_status_q[2*h]) begin
        any_fail   = 1'b1;
        first_fail = FH_WIDTH'(h);
      end
      if (hart_status_q[2*h +: 2] != HS_PASS) begin
        all_pass = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hart_status_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        hang_cnt[h] <= '0;
        last_pc[h]  <= '0;
      end
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (accept[h]) begin
          if (pc_h[h] == PC_FAILED) begin
            hart_status_q[2*h +: 2] <= HS_FAIL;
          end else if (pc_h[h] == PC_SUCCESS) begin
            hart_status_q[2*h +: 2] <= HS_PASS;
          end else begin
            hang_cnt[h] <= hang_nxt[h];
            last_pc[h]  <= pc_h[h];
            if (HANG_EN && (hang_nxt[h] == HANG_LIM_C)) begin
              hart_status_q[2*h +: 2] <= HS_HANG;
            end
          end
        end
      end
    end
  end

  // Global verdict FSM. It looks at the registered hart status, which adds the
  // second cycle of commit-to-verdict latency; the priority is FAIL > PASS > TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      result_q       <= 2'b00;
      done_q         <= 1'b0;
      fail_hart_q    <= '0;
      cycle_count_q  <= '0;
      retire_count_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mon.enable) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          cycle_count_q  <= (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_WIDTH'(1);
          retire_count_q <= retire_nxt;
          if (any_fail) begin
            state       <= S_FAIL;
            result_q    <= 2'b01;
            done_q      <= 1'b1;
            fail_hart_q <= first_fail;
          end else if (all_pass) begin
            state    <= S_PASS;
            result_q <= 2'b10;
            done_q   <= 1'b1;
          end else if (TO_EN && (cycle_count_q == TO_LAST)) begin
            state    <= S_TIMEOUT;
            result_q <= 2'b11;
            done_q   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mon.result       = result_q;
  assign mon.done         = done_q;
  assign mon.fail_hart    = fail_hart_q;
  assign mon.cycle_count  = cycle_count_q;
  assign mon.retire_count = retire_count_q;
  assign mon.hart_status  = hart_status_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// tb/tb_test_result_monitor.sv - randomized and directed bench for test_result_monitor against a behavioural model
// Three monitors run side by side:
//   d0: 2 harts, HANG_LIMIT 4, TIMEOUT 60, 32-bit counters
//   d1: 1 hart,  HANG_LIMIT 1024, TIMEOUT 10, 32-bit counters
//   d2: 3 harts, hang and timeout disabled, 3-bit counters (saturation)
module tb_test_result_monitor;

  localparam int ND = 3;
  localparam int G_IDLE = 0, G_RUN = 1, G_PASS = 2, G_FAIL = 3, G_TO = 4;
  localparam int H_RUN = 0, H_PASS = 1, H_FAIL = 2, H_HANG = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        en  [ND];
  logic [3:0]  cv  [ND];
  logic [31:0] pcs [ND][4];

  int n_checks;
  int n_errors;

  test_result_monitor_if #(.NUM_HARTS(2), .PC_WIDTH(32), .CNT_WIDTH(32), .FH_WIDTH(1)) ifa ();
  test_result_monitor_if #(.NUM_HARTS(1), .PC_WIDTH(32), .CNT_WIDTH(32), .FH_WIDTH(1)) ifb ();
  test_result_monitor_if #(.NUM_HARTS(3), .PC_WIDTH(32), .CNT_WIDTH(3),  .FH_WIDTH(2)) ifc ();

  assign ifa.enable       = en[0];
  assign ifa.commit_valid = cv[0][1:0];
  assign ifa.commit_pc    = {pcs[0][1], pcs[0][0]};
  assign ifb.enable       = en[1];
  assign ifb.commit_valid = cv[1][0:0];
  assign ifb.commit_pc    = pcs[1][0];
  assign ifc.enable       = en[2];
  assign ifc.commit_valid = cv[2][2:0];
  assign ifc.commit_pc    = {pcs[2][2], pcs[2][1], pcs[2][0]};

  test_result_monitor #(
    .NUM_HARTS(2), .PC_WIDTH(32), .PC_SUCCESS(32'h1000), .PC_FAILED(32'h2000),
    .TIMEOUT_CYCLES(60), .HANG_LIMIT(4), .CNT_WIDTH(32), .FH_WIDTH(1)
  ) dut_a (.clk(clk), .reset(reset), .mon(ifa));

  test_result_monitor #(
    .NUM_HARTS(1), .PC_WIDTH(32), .PC_SUCCESS(32'h1000), .PC_FAILED(32'h2000),
    .TIMEOUT_CYCLES(10), .HANG_LIMIT(1024), .CNT_WIDTH(32), .FH_WIDTH(1)
  ) dut_b (.clk(clk), .reset(reset), .mon(ifb));

  test_result_monitor #(
    .NUM_HARTS(3), .PC_WIDTH(32), .PC_SUCCESS(32'h1000), .PC_FAILED(32'h2000),
    .TIMEOUT_CYCLES(0), .HANG_LIMIT(0), .CNT_WIDTH(3), .FH_WIDTH(2)
  ) dut_c (.clk(clk), .reset(reset), .mon(ifc));

  function automatic int nh_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 3;
  endfunction
  function automatic int to_of(input int d);
    return (d == 0) ? 60 : (d == 1) ? 10 : 0;
  endfunction
  function automatic int hl_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1024 : 0;
  endfunction
  function automatic int cw_of(input int d);
    return (d == 2) ? 3 : 32;
  endfunction

  // Behavioural model state
  int          m_g   [ND];
  int          m_hs  [ND][4];
  longint      m_hc  [ND][4];
  logic [31:0] m_lpc [ND][4];
  longint      m_cyc [ND];
  longint      m_ret [ND];
  int          m_fh  [ND];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_g[d] = G_IDLE; m_cyc[d] = 0; m_ret[d] = 0; m_fh[d] = 0;
    for (int h = 0; h < 4; h++) begin
      m_hs[d][h] = H_RUN; m_hc[d][h] = 0; m_lpc[d][h] = '0;
    end
  endtask

  // One clock edge of the monitor, straight from the behavioural rules.
  task automatic model_step(input int d);
    int     g_next;
    int     fh;
    bit     anyf;
    bit     allp;
    bit     run;
    longint acc;
    longint cmax;
    cmax   = (64'd1 << cw_of(d)) - 1;
    run    = (m_g[d] == G_RUN);
    g_next = m_g[d];
    acc    = 0;
    if (m_g[d] == G_IDLE) begin
      if (en[d]) g_next = G_RUN;
    end else if (run) begin
      anyf = 0; allp = 1; fh = -1;
      for (int h = 0; h < nh_of(d); h++) begin
        if (m_hs[d][h] == H_FAIL || m_hs[d][h] == H_HANG) begin
          anyf = 1;
          if (fh < 0) fh = h;
        end
        if (m_hs[d][h] != H_PASS) allp = 0;
      end
      if (anyf) begin
        g_next = G_FAIL; m_fh[d] = fh;
      end else if (allp) begin
        g_next = G_PASS;
      end else if (to_of(d) != 0 && m_cyc[d] == to_of(d) - 1) begin
        g_next = G_TO;
      end
      if (m_cyc[d] < cmax) m_cyc[d]++;
    end
    if (run) begin
      for (int h = 0; h < nh_of(d); h++) begin
        if (cv[d][h] && m_hs[d][h] == H_RUN) begin
          acc++;
          if (pcs[d][h] == 32'h2000) m_hs[d][h] = H_FAIL;
          else if (pcs[d][h] == 32'h1000) m_hs[d][h] = H_PASS;
          else begin
            if (pcs[d][h] == m_lpc[d][h]) m_hc[d][h]++;
            else begin
              m_hc[d][h] = 1; m_lpc[d][h] = pcs[d][h];
            end
            if (hl_of(d) != 0 && m_hc[d][h] == hl_of(d)) m_hs[d][h] = H_HANG;
          end
        end
      end
    end
    m_ret[d] = (m_ret[d] + acc > cmax) ? cmax : m_ret[d] + acc;
    m_g[d] = g_next;
  endtask

  task automatic compare_dut(input int d);
    logic [63:0] o_r, o_d, o_hs, o_fh, o_cc, o_rc;
    logic [63:0] e_r, e_hs, code;
    case (d)
      0: begin
        o_r = 64'(ifa.result); o_d = 64'(ifa.done); o_hs = 64'(ifa.hart_status);
        o_fh = 64'(ifa.fail_hart); o_cc = 64'(ifa.cycle_count); o_rc = 64'(ifa.retire_count);
      end
      1: begin
        o_r = 64'(ifb.result); o_d = 64'(ifb.done); o_hs = 64'(ifb.hart_status);
        o_fh = 64'(ifb.fail_hart); o_cc = 64'(ifb.cycle_count); o_rc = 64'(ifb.retire_count);
      end
      default: begin
        o_r = 64'(ifc.result); o_d = 64'(ifc.done); o_hs = 64'(ifc.hart_status);
        o_fh = 64'(ifc.fail_hart); o_cc = 64'(ifc.cycle_count); o_rc = 64'(ifc.retire_count);
      end
    endcase
    case (m_g[d])
      G_PASS:  e_r = 64'h2;
      G_FAIL:  e_r = 64'h1;
      G_TO:    e_r = 64'h3;
      default: e_r = 64'h0;
    endcase
    e_hs = '0;
    for (int h = 0; h < nh_of(d); h++) begin
      case (m_hs[d][h])
        H_PASS:  code = 64'h2;
        H_FAIL:  code = 64'h1;
        H_HANG:  code = 64'h3;
        default: code = 64'h0;
      endcase
      e_hs = e_hs | (code << (2 * h));
    end
    check($sformatf("d%0d result", d), o_r, e_r);
    check($sformatf("d%0d done", d), o_d, {63'd0, e_r != 0});
    check($sformatf("d%0d hart_status", d), o_hs, e_hs);
    check($sformatf("d%0d fail_hart", d), o_fh, (m_g[d] == G_FAIL) ? 64'(m_fh[d]) : 64'h0);
    check($sformatf("d%0d cycle_count", d), o_cc, 64'(m_cyc[d]));
    check($sformatf("d%0d retire_count", d), o_rc, 64'(m_ret[d]));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < ND; d++) model_step(d);
    #1;
    for (int d = 0; d < ND; d++) compare_dut(d);
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < ND; d++) begin
      en[d] = 1'b0; cv[d] = '0;
      for (int h = 0; h < 4; h++) pcs[d][h] = '0;
    end
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    for (int d = 0; d < ND; d++) model_reset(d);
    for (int d = 0; d < ND; d++) compare_dut(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) compare_dut(d);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] plain_pc();
    return 32'h4000 + 32'(4 * $urandom_range(0, 255));
  endfunction

  task automatic rand_inputs(input int d);
    int r;
    for (int h = 0; h < nh_of(d); h++) begin
      cv[d][h] = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 99);
      if (r < 3)       pcs[d][h] = 32'h1000;
      else if (r < 6)  pcs[d][h] = 32'h2000;
      else if (r < 60) pcs[d][h] = 32'h40 + 32'(4 * $urandom_range(0, 1));
      else             pcs[d][h] = plain_pc();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    clear_inputs();
    pulse_reset();

    // Single hart: 0x0, 0x4, 0x8, 0x1000 then a late 0x2000. d0/d2 never enabled.
    en[1] = 1'b1; tick(); en[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cv[1] = 4'b0001;
      pcs[1][0] = (i == 3) ? 32'h1000 : 32'(4 * i);
      tick();
    end
    check("b hart pass after commit edge", 64'(ifb.hart_status), 64'h2);
    check("b result lags one cycle", 64'(ifb.result), 64'h0);
    pcs[1][0] = 32'h2000;
    tick();
    cv[1] = '0;
    check("b result pass", 64'(ifb.result), 64'h2);
    check("b retire four", 64'(ifb.retire_count), 64'd4);
    for (int i = 0; i < 20; i++) tick();
    check("b pass sticky", 64'(ifb.result), 64'h2);
    check("a never enabled stays idle", 64'(ifa.result), 64'h0);
    check("c never enabled stays idle", 64'(ifc.cycle_count), 64'h0);

    // d0: hart0 pass at cycle 3, hart1 fail at cycle 7. d1: timeout. d2: saturation.
    pulse_reset();
    for (int d = 0; d < ND; d++) en[d] = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) en[d] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      cv[0] = (c == 3) ? 4'b0001 : (c == 7) ? 4'b0010 : 4'b0000;
      pcs[0][0] = 32'h1000;
      pcs[0][1] = 32'h2000;
      cv[1] = {3'b000, 1'($urandom_range(0, 1))};
      pcs[1][0] = plain_pc();
      cv[2] = 4'b0111;
      for (int h = 0; h < 3; h++) pcs[2][h] = plain_pc();
      tick();
    end
    clear_inputs();
    check("a hart_status pass/fail", 64'(ifa.hart_status), 64'h6);
    check("a result fail", 64'(ifa.result), 64'h1);
    check("a fail_hart 1", 64'(ifa.fail_hart), 64'h1);
    check("a cycle_count frozen", 64'(ifa.cycle_count), 64'd8);
    check("b timeout", 64'(ifb.result), 64'h3);
    check("b timeout cycles", 64'(ifb.cycle_count), 64'd10);
    check("b timeout done", 64'(ifb.done), 64'h1);
    check("c cycle saturated", 64'(ifc.cycle_count), 64'd7);
    check("c retire saturated", 64'(ifc.retire_count), 64'd7);

    // Same-cycle pass and fail on two harts.
    pulse_reset();
    en[0] = 1'b1; tick(); en[0] = 1'b0;
    tick();
    cv[0] = 4'b0011; pcs[0][0] = 32'h1000; pcs[0][1] = 32'h2000;
    tick();
    cv[0] = '0;
    check("a simultaneous hart_status", 64'(ifa.hart_status), 64'h6);
    check("a simultaneous result lags", 64'(ifa.result), 64'h0);
    tick();
    check("a simultaneous fail", 64'(ifa.result), 64'h1);
    check("a simultaneous fail_hart", 64'(ifa.fail_hart), 64'h1);

    // Hang on hart0: four 0x40 commits, without and with an idle gap.
    for (int gap = 0; gap < 2; gap++) begin
      pulse_reset();
      en[0] = 1'b1; tick(); en[0] = 1'b0;
      for (int s = 0; s < 4 + gap; s++) begin
        cv[0] = (gap == 1 && s == 2) ? 4'b0000 : 4'b0001;
        pcs[0][0] = 32'h40;
        tick();
        if (s == 2 + gap) check($sformatf("a not hung before 4th gap%0d", gap), 64'(ifa.hart_status[1:0]), 64'h0);
      end
      cv[0] = '0;
      check($sformatf("a hart0 hang gap%0d", gap), 64'(ifa.hart_status[1:0]), 64'h3);
      tick();
      check($sformatf("a hang result gap%0d", gap), 64'(ifa.result), 64'h1);
      check($sformatf("a hang fail_hart gap%0d", gap), 64'(ifa.fail_hart), 64'h0);
    end

    // Asynchronous reset mid-run, then a fresh run.
    pulse_reset();
    for (int d = 0; d < ND; d++) en[d] = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) en[d] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cv[0] = 4'b0011; pcs[0][0] = plain_pc(); pcs[0][1] = plain_pc();
      tick();
    end
    clear_inputs();
    #3;
    reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) model_reset(d);
    for (int d = 0; d < ND; d++) compare_dut(d);
    check("a async reset cycle_count", 64'(ifa.cycle_count), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    en[0] = 1'b1; tick(); en[0] = 1'b0;
    tick();
    check("a fresh run cycle_count", 64'(ifa.cycle_count), 64'd1);

    // Randomized soak against the model.
    for (int run = 0; run < 10; run++) begin
      pulse_reset();
      for (int c = 0; c < 70; c++) begin
        for (int d = 0; d < ND; d++) begin
          en[d] = ($urandom_range(0, 3) == 0);
          rand_inputs(d);
        end
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
